// File: rtl/sobel_window_scanner.sv
// -----------------------------------------------------------------------------
// sobel_window_scanner
//
// Walks a 3x3 window across a frame held in the upstream window memory, in
// raster order, one window position per cycle. For every position it computes
// the Sobel gradient magnitude |Gx|+|Gy|, saturated to 8 bits, and a
// thresholded edge bit.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             single-cycle pulse, accepted only when idle
//   H, W              frame height/width, captured on an accepted start
//   data0..data8      window bytes from the memory, row-major, registered there
//   read_H, read_W    window top-left address to the memory
//   mem_ready         memory read-enable (low lets the loader write)
//   out_pixel         saturated gradient magnitude
//   out_edge          out_pixel >= THRESH
//   out_valid         output qualifier (no backpressure)
//   out_row, out_col  top-left coordinates of the window behind the output
//   busy              high from scan entry until the done cycle ends
//   done              single-cycle completion pulse
//
// Pipeline: address issued in cycle n -> memory data in n+1 -> |Gx|,|Gy|
// registered at end of n+1 -> output registered at end of n+2 (visible n+3).
// -----------------------------------------------------------------------------
module sobel_window_scanner #(
    parameter int THRESH = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] H,
    input  logic [15:0] W,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    input  logic [7:0]  data2,
    input  logic [7:0]  data3,
    input  logic [7:0]  data4,
    input  logic [7:0]  data5,
    input  logic [7:0]  data6,
    input  logic [7:0]  data7,
    input  logic [7:0]  data8,
    output logic [15:0] read_H,
    output logic [15:0] read_W,
    output logic        mem_ready,
    output logic [7:0]  out_pixel,
    output logic        out_edge,
    output logic        out_valid,
    output logic [15:0] out_row,
    output logic [15:0] out_col,
    output logic        busy,
    output logic        done
);

    // Threshold clamped into 9 bits so any THRESH above 255 simply never fires.
    localparam logic [8:0] THRESH_9 = (THRESH > 255) ? 9'd256 : 9'(THRESH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] hl_reg, wl_reg;
    logic [15:0] row_reg, col_reg;
    logic [1:0]  drain_cnt_reg;

    logic        degenerate;
    logic        last_col;
    logic        last_pos;
    logic        issue;

    // Frames smaller than one window produce no reads at all.
    assign degenerate = (H < 16'd3) || (W < 16'd3);
    assign last_col   = (col_reg == wl_reg - 16'd3);
    assign last_pos   = last_col && (row_reg == hl_reg - 16'd3);

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = degenerate ? ST_DONE : ST_SCAN;
            ST_SCAN:  if (last_pos) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt_reg == 2'd2) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_reg)
            ST_SCAN:  begin mem_ready = 1'b1; busy = 1'b1; end
            ST_DRAIN: begin mem_ready = 1'b1; busy = 1'b1; end
            ST_DONE:  begin busy = 1'b1; done = 1'b1; end
            default:  ;
        endcase
    end

    // ------------------------------------------------- address generation ---
    always_ff @(posedge clk) begin
        if (rst) begin
            hl_reg        <= '0;
            wl_reg        <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            drain_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        hl_reg  <= H;
                        wl_reg  <= W;
                        row_reg <= '0;
                        col_reg <= '0;
                    end
                end
                ST_SCAN: begin
                    drain_cnt_reg <= '0;
                    // Address stays on the final position through DRAIN.
                    if (!last_pos) begin
                        if (last_col) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 16'd1;
                        end else begin
                            col_reg <= col_reg + 16'd1;
                        end
                    end
                end
                ST_DRAIN: drain_cnt_reg <= drain_cnt_reg + 2'd1;
                default:  ;
            endcase
        end
    end

    assign read_H = row_reg;
    assign read_W = col_reg;
    assign issue  = (state_reg == ST_SCAN);

    // ------------------------------------------- valid/coordinate delay line ---
    // Index 0: data arriving from memory, 1: gradients registered, 2: output.
    logic [2:0]  pipe_valid_reg;
    logic [15:0] pipe_row_reg [3];
    logic [15:0] pipe_col_reg [3];

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg <= '0;
            for (int i = 0; i < 3; i++) begin
                pipe_row_reg[i] <= '0;
                pipe_col_reg[i] <= '0;
            end
        end else begin
            pipe_valid_reg  <= {pipe_valid_reg[1:0], issue};
            pipe_row_reg[0] <= row_reg;
            pipe_col_reg[0] <= col_reg;
            for (int i = 1; i < 3; i++) begin
                pipe_row_reg[i] <= pipe_row_reg[i-1];
                pipe_col_reg[i] <= pipe_col_reg[i-1];
            end
        end
    end

    // ------------------------------------------------- stage 1: gradients ---
    // Each gradient is split into its positive and negative weighted sums
    // (both <= 1020, fit in 10 bits) so the absolute value is a plain
    // compare-and-subtract without any signed arithmetic.
    logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [9:0] abs_gx_next, abs_gy_next;
    logic [9:0] abs_gx_reg, abs_gy_reg;

    always_comb begin
        gx_pos = {2'b00, data2} + {1'b0, data5, 1'b0} + {2'b00, data8};
        gx_neg = {2'b00, data0} + {1'b0, data3, 1'b0} + {2'b00, data6};
        gy_pos = {2'b00, data6} + {1'b0, data7, 1'b0} + {2'b00, data8};
        gy_neg = {2'b00, data0} + {1'b0, data1, 1'b0} + {2'b00, data2};
        abs_gx_next = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
        abs_gy_next = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abs_gx_reg <= '0;
            abs_gy_reg <= '0;
        end else begin
            abs_gx_reg <= abs_gx_next;
            abs_gy_reg <= abs_gy_next;
        end
    end

    // ---------------------------------------- stage 2: saturate, threshold ---
    logic [10:0] mag_sum;
    logic [7:0]  pixel_next;
    logic        edge_next;
    logic [7:0]  pixel_reg;
    logic        edge_reg;

    always_comb begin
        mag_sum    = {1'b0, abs_gx_reg} + {1'b0, abs_gy_reg};
        pixel_next = (mag_sum > 11'd255) ? 8'hFF : mag_sum[7:0];
        edge_next  = ({1'b0, pixel_next} >= THRESH_9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_reg <= '0;
            edge_reg  <= 1'b0;
        end else begin
            pixel_reg <= pixel_next;
            edge_reg  <= edge_next;
        end
    end

    assign out_pixel = pixel_reg;
    assign out_edge  = edge_reg;
    assign out_valid = pipe_valid_reg[2];
    assign out_row   = pipe_row_reg[2];
    assign out_col   = pipe_col_reg[2];

endmodule

// File: tb/tb_sobel_window_scanner.sv
// -----------------------------------------------------------------------------
// Directed testbench for sobel_window_scanner. A behavioural frame memory
// registers the 3x3 window on each enabled read; each scenario task drives
// start and checks outputs cycle by cycle against hand-derived values.
// -----------------------------------------------------------------------------
module tb_sobel_window_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] H, W;
    logic [7:0]  d [9];
    logic [15:0] read_H, read_W, out_row, out_col;
    logic        mem_ready, out_edge, out_valid, busy, done;
    logic [7:0]  out_pixel;

    logic [7:0]  frame [0:15][0:15];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sobel_window_scanner #(.THRESH(128)) dut (
        .clk(clk), .rst(rst), .start(start), .H(H), .W(W),
        .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]), .data4(d[4]),
        .data5(d[5]), .data6(d[6]), .data7(d[7]), .data8(d[8]),
        .read_H(read_H), .read_W(read_W), .mem_ready(mem_ready),
        .out_pixel(out_pixel), .out_edge(out_edge), .out_valid(out_valid),
        .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
    );

    // Frame memory model: window registered at the end of the address cycle.
    always @(posedge clk) begin
        if (mem_ready) begin
            for (int i = 0; i < 9; i++)
                d[i] <= frame[(int'(read_H) + i / 3) & 15][(int'(read_W) + i % 3) & 15];
        end
    end

    task automatic fill_frame(input int mode, input int v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                case (mode)
                    0: frame[r][c] = 8'(v);                      // uniform
                    1: frame[r][c] = 8'(10 * c);                 // ramp
                    2: frame[r][c] = (c == 2) ? 8'd255 : 8'd0;   // step column
                    3: frame[r][c] = (r == 0) ? 8'd50 : 8'd0;    // top row bright
                    default: frame[r][c] = (r == 1 && c == 2) ? 8'(v) : 8'd0;
                endcase
            end
    endtask

    // Full scan of an h x w frame where every window yields exp_pix/exp_edge.
    // restart_k > 0 pulses start (with a different H/W) in cycle s+restart_k.
    task automatic run_scan(input string name, input int h, input int w,
                            input logic [7:0] exp_pix, input logic exp_edge,
                            input int restart_k);
        int n, nout, er, ec, ah, aw;
        logic exp_v;
        n = (h - 2) * (w - 2);
        nout = 0; er = 0; ec = 0;
        @(negedge clk);
        H = 16'(h); W = 16'(w); start = 1'b1;
        for (int k = 1; k <= n + 8; k++) begin
            @(negedge clk);
            start = (k == restart_k);
            if (k == restart_k) begin H = 16'(h + 3); W = 16'(w + 3); end
            checks++;
            if (mem_ready !== (k <= n + 3)) begin
                errors++;
                $display("FAIL %s mem_ready k=%0d got %0b exp %0b", name, k, mem_ready, (k <= n + 3));
            end
            checks++;
            if (busy !== (k <= n + 4)) begin
                errors++;
                $display("FAIL %s busy k=%0d got %0b exp %0b", name, k, busy, (k <= n + 4));
            end
            checks++;
            if (done !== (k == n + 4)) begin
                errors++;
                $display("FAIL %s done k=%0d got %0b exp %0b", name, k, done, (k == n + 4));
            end
            if (k <= n + 3) begin
                ah = (k <= n) ? (k - 1) / (w - 2) : h - 3;
                aw = (k <= n) ? (k - 1) % (w - 2) : w - 3;
                checks++;
                if (read_H !== 16'(ah) || read_W !== 16'(aw)) begin
                    errors++;
                    $display("FAIL %s addr k=%0d got (%0d,%0d) exp (%0d,%0d)", name, k, read_H, read_W, ah, aw);
                end
            end
            exp_v = (k >= 4) && (k <= n + 3);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL %s out_valid k=%0d got %0b exp %0b", name, k, out_valid, exp_v);
            end
            if (out_valid === 1'b1 && exp_v) begin
                nout++;
                checks++;
                if (out_row !== 16'(er) || out_col !== 16'(ec)) begin
                    errors++;
                    $display("FAIL %s coord k=%0d got (%0d,%0d) exp (%0d,%0d)", name, k, out_row, out_col, er, ec);
                end
                checks++;
                if (out_pixel !== exp_pix || out_edge !== exp_edge) begin
                    errors++;
                    $display("FAIL %s pixel (%0d,%0d) got %0d/%0b exp %0d/%0b", name, er, ec, out_pixel, out_edge, exp_pix, exp_edge);
                end
                if (ec == w - 3) begin ec = 0; er++; end else ec++;
            end
        end
        checks++;
        if (nout !== n) begin
            errors++;
            $display("FAIL %s count got %0d exp %0d", name, nout, n);
        end
        $display("scan %s %0dx%0d: %0d outputs (expected %0d)", name, h, w, nout, n);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; H = '0; W = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({mem_ready, busy, done, out_valid, out_edge} !== 5'b0 ||
            read_H !== 16'd0 || read_W !== 16'd0 || out_pixel !== 8'd0 ||
            out_row !== 16'd0 || out_col !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got ctl=%b rd=(%0d,%0d) pix=%0d exp all zero",
                     {mem_ready, busy, done, out_valid, out_edge}, read_H, read_W, out_pixel);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_degenerate(input int h, input int w);
        @(negedge clk);
        H = 16'(h); W = 16'(w); start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (done !== (k == 1) || busy !== (k == 1)) begin
                errors++;
                $display("FAIL degenerate_done k=%0d got done=%0b busy=%0b exp %0b", k, done, busy, (k == 1));
            end
            checks++;
            if (mem_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL degenerate_quiet k=%0d got mem_ready=%0b out_valid=%0b exp 0", k, mem_ready, out_valid);
            end
        end
        $display("degenerate %0dx%0d: done pulse checked", h, w);
    endtask

    task automatic test_reset_mid_scan();
        fill_frame(1, 0);
        @(negedge clk);
        H = 16'd8; W = 16'd8; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;                 // asserted in cycle s+10
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({mem_ready, busy, done, out_valid} !== 4'b0 || read_H !== 16'd0 ||
            read_W !== 16'd0 || out_pixel !== 8'd0) begin
            errors++;
            $display("FAIL midreset_state got ctl=%b rd=(%0d,%0d) pix=%0d exp zero",
                     {mem_ready, busy, done, out_valid}, read_H, read_W, out_pixel);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet k=%0d got valid=%0b done=%0b busy=%0b exp 0", k, out_valid, done, busy);
            end
        end
        $display("reset mid-scan: pipeline flush checked");
        run_scan("after_reset_8x8", 8, 8, 8'd80, 1'b0, 0);
    endtask

    task automatic test_start_with_rst();
        @(negedge clk);
        H = 16'd5; W = 16'd5; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy !== 1'b0 || mem_ready !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL start_with_rst k=%0d got busy=%0b mem_ready=%0b done=%0b exp 0", k, busy, mem_ready, done);
            end
            @(negedge clk);
        end
        $display("start coincident with rst: ignored");
    endtask

    initial begin
        test_reset();

        fill_frame(0, 100);
        run_scan("uniform", 5, 5, 8'd0, 1'b0, 0);

        fill_frame(2, 0);
        run_scan("saturate", 3, 3, 8'd255, 1'b1, 0);

        fill_frame(1, 0);
        run_scan("ramp", 4, 6, 8'd80, 1'b0, 0);

        fill_frame(3, 0);
        run_scan("neg_gy", 3, 3, 8'd200, 1'b1, 0);

        fill_frame(4, 63);
        run_scan("below_thresh", 3, 3, 8'd126, 1'b0, 0);

        fill_frame(4, 64);
        run_scan("at_thresh", 3, 3, 8'd128, 1'b1, 0);

        test_degenerate(2, 10);
        test_degenerate(10, 2);

        test_reset_mid_scan();

        fill_frame(1, 0);
        run_scan("restart_ignored", 5, 5, 8'd80, 1'b0, 3);
        run_scan("back_to_back", 4, 5, 8'd80, 1'b0, 0);

        test_start_with_rst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
